// File: rtl/rv_pkg.sv
// Shared RV32I decode helpers and X-stage hazard types.
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FNC_CSRRW  = 3'b001;

  // One retired-from-X instruction as seen by the forwarding logic.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       writes_rd;
    logic       is_load;
  } hist_entry_t;

  typedef enum logic {IDLE, FLUSH} flush_state_t;

  function automatic logic uses_rs1(input logic [6:0] opc, input logic [2:0] funct3);
    case (opc)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: uses_rs1 = 1'b1;
      OPC_SYSTEM: uses_rs1 = (funct3 == FNC_CSRRW);
      default:    uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default:                      uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_LOAD, OPC_JAL, OPC_JALR,
      OPC_AUIPC, OPC_LUI, OPC_SYSTEM: writes_rd = 1'b1;
      default:                        writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [6:0] opc);
    is_load = (opc == OPC_LOAD);
  endfunction

endpackage

// File: rtl/x_fwd_match.sv
// Youngest-producer search over the X-stage history for one source register.
module x_fwd_match
  import rv_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  hist_entry_t [DEPTH-1:0] hist,
  input  logic [4:0]              rs,
  input  logic                    used,
  output logic [SELW-1:0]         sel,
  output logic                    load_hazard
);

  // Scan oldest to youngest so the youngest matching producer overrides older ones.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    sel         = '0;
    load_hazard = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used && rs != 5'd0 && hist[i].valid && hist[i].writes_rd && hist[i].rd == rs) begin
        sel         = SELW'(i + 1);
        load_hazard = hist[i].is_load && (i < LOAD_LAT - 1);
      end
    end
  end

endmodule

// File: rtl/x_hazard_ctrl.sv
// X-stage forwarding select, load-use stall and multi-cycle redirect flush control.
module x_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int SELW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            x_valid,
  input  logic [31:0]     x_inst,
  input  logic            x_redirect,
  input  logic            stall_in,
  output logic [SELW-1:0] fwd_a_sel,
  output logic [SELW-1:0] fwd_b_sel,
  output logic            stall_out,
  output logic            flush
);

  hist_entry_t [DEPTH-1:0] hist;
  flush_state_t            state;
  logic [3:0]              cnt;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [SELW-1:0] sel_a, sel_b;
  logic            haz_a, haz_b;
  logic            squashed, stall_raw, redirect, advance;
  hist_entry_t     new_entry;

  assign opc    = x_inst[6:0];
  assign rd     = x_inst[11:7];
  assign funct3 = x_inst[14:12];
  assign rs1    = x_inst[19:15];
  assign rs2    = x_inst[24:20];

  x_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_match_a (
    .hist        (hist),
    .rs          (rs1),
    .used        (uses_rs1(opc, funct3)),
    .sel         (sel_a),
    .load_hazard (haz_a)
  );

  x_fwd_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_match_b (
    .hist        (hist),
    .rs          (rs2),
    .used        (uses_rs2(opc)),
    .sel         (sel_b),
    .load_hazard (haz_b)
  );

  // Squash, stall and redirect qualification for the instruction currently in X.
  always_comb begin
    squashed  = (state == FLUSH);
    stall_raw = x_valid && !squashed && (haz_a || haz_b);
    redirect  = (state == IDLE) && x_valid && x_redirect && !stall_raw;
    advance   = !stall_in;
    new_entry = '{valid:     x_valid && !squashed && !stall_raw,
                  rd:        rd,
                  writes_rd: writes_rd(opc),
                  is_load:   is_load(opc)};
  end

  // Outputs are forced low for as long as reset is held, whatever the inputs do.
  always_comb begin
    fwd_a_sel = reset ? '0 : sel_a;
    fwd_b_sel = reset ? '0 : sel_b;
    stall_out = !reset && stall_raw;
    flush     = !reset && (squashed || redirect);
  end

  // History shift: the X instruction (or a bubble while stalling) enters at index 0.
  always_ff @(posedge clk) begin
    // NOTE: the history holds valid bits, so it must be cleared on reset unlike a plain data RAM.
    if (reset) begin
      hist <= '0;
    end else if (advance) begin
      // NOTE: non-blocking so every stage shifts from the pre-edge value of its neighbour.
      hist[0] <= new_entry;
      for (int i = 1; i < DEPTH; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  // Flush window: held for FLUSH_CYCLES advancing cycles after the redirect cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (advance) begin
      case (state)
        IDLE: begin
          if (redirect) begin
            state <= FLUSH;
            cnt   <= 4'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          if (cnt == 4'd1) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_hazard_ctrl.sv
// Directed and randomized bench for x_hazard_ctrl with a queue-based reference model.
module tb_x_hazard_ctrl;

  localparam int DEPTH        = 2;
  localparam int LOAD_LAT     = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int SELW         = $clog2(DEPTH + 1);

  localparam bit [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011,
                       O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                       O_JALR = 7'b1100111, O_AUIPC = 7'b0010111, O_LUI = 7'b0110111,
                       O_SYS = 7'b1110011, O_FENCE = 7'b0001111;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            x_valid = 1'b0;
  logic [31:0]     x_inst = '0;
  logic            x_redirect = 1'b0;
  logic            stall_in = 1'b0;
  logic [SELW-1:0] fwd_a_sel, fwd_b_sel;
  logic            stall_out, flush;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  x_hazard_ctrl #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .x_valid    (x_valid),
    .x_inst     (x_inst),
    .x_redirect (x_redirect),
    .stall_in   (stall_in),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall_out  (stall_out),
    .flush      (flush)
  );

  function automatic logic [31:0] enc(input int f7, input int rs2, input int rs1,
                                      input int f3, input int rd, input bit [6:0] opc);
    enc = {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1);
    addi = enc(0, 1, rs1, 0, rd, O_I);
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    add = enc(0, rs2, rs1, 0, rd, O_R);
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- reference model ----------------
  typedef struct {bit v; int rd; bit wr; bit ld;} ent_t;
  ent_t hq[$];          // hq[0] = most recent instruction to leave X
  int   flush_rem = 0;  // flush cycles still owed after the redirect cycle
  int   m_a, m_b;
  bit   m_stall, m_flush, m_redir;

  function automatic void tb_decode(input logic [31:0] i, output bit u1, output bit u2,
                                    output bit wr, output bit ld);
    u1 = 0; u2 = 0; wr = 0; ld = 0;
    case (i[6:0])
      O_R:             begin u1 = 1; u2 = 1; wr = 1; end
      O_I:             begin u1 = 1; wr = 1; end
      O_LD:            begin u1 = 1; wr = 1; ld = 1; end
      O_ST, O_BR:      begin u1 = 1; u2 = 1; end
      O_JAL:           wr = 1;
      O_JALR:          begin u1 = 1; wr = 1; end
      O_AUIPC, O_LUI:  wr = 1;
      O_SYS:           begin wr = 1; u1 = (i[14:12] == 3'b001); end
      default:         ;
    endcase
  endfunction

  function automatic void lookup(input int rs, input bit used, output int sel, output bit haz);
    sel = 0; haz = 0;
    if (!used || rs == 0) return;
    foreach (hq[k]) begin
      if (hq[k].v && hq[k].wr && hq[k].rd == rs) begin
        sel = k + 1;
        haz = hq[k].ld && (k < LOAD_LAT - 1);
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    bit u1, u2, wr, ld, ha, hb, sq;
    tb_decode(x_inst, u1, u2, wr, ld);
    sq = flush_rem > 0;
    lookup(int'(x_inst[19:15]), u1, m_a, ha);
    lookup(int'(x_inst[24:20]), u2, m_b, hb);
    m_stall = x_valid && !sq && (ha || hb);
    m_redir = x_valid && x_redirect && !sq && !m_stall;
    m_flush = sq || m_redir;
    if (reset) begin
      m_a = 0; m_b = 0; m_stall = 0; m_flush = 0;
    end
  endfunction

  always @(posedge clk) begin
    bit u1, u2, wr, ld;
    ent_t e;
    model_eval();
    if (reset) begin
      hq.delete();
      for (int k = 0; k < DEPTH; k++) hq.push_back('{0, 0, 0, 0});
      flush_rem = 0;
    end else if (!stall_in) begin
      tb_decode(x_inst, u1, u2, wr, ld);
      e = '{x_valid && (flush_rem == 0) && !m_stall, int'(x_inst[11:7]), wr, ld};
      hq.push_front(e);
      void'(hq.pop_back());
      if (m_redir) flush_rem = FLUSH_CYCLES;
      else if (flush_rem > 0) flush_rem--;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {bit rst; bit v; logic [31:0] inst; bit r; bit si;
                  int ea; int eb; bit es; bit ef;} vec_t;

  function automatic vec_t mk(input bit rst, input bit v, input logic [31:0] inst, input bit r,
                              input bit si, input int ea, input int eb, input bit es, input bit ef);
    mk = '{rst, v, inst, r, si, ea, eb, es, ef};
  endfunction

  task automatic drive(input bit rst, input bit v, input logic [31:0] inst,
                       input bit r, input bit si);
    @(negedge clk);
    reset = rst; x_valid = v; x_inst = inst; x_redirect = r; stall_in = si;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, $urandom, 1, $urandom_range(0, 1));
      vectors++;
      if (fwd_a_sel !== '0 || fwd_b_sel !== '0 || stall_out !== 1'b0 || flush !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got a=%0d b=%0d stall=%b flush=%b, want all 0",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t[$] = '{
      mk(0, 1, addi(5, 0),   0, 0, 0, 0, 0, 0),
      mk(0, 1, add(6, 5, 5), 0, 0, 1, 1, 0, 0),
      mk(0, 1, addi(5, 0),   0, 0, 0, 0, 0, 0),
      mk(0, 1, NOP,          0, 0, 0, 0, 0, 0),
      mk(0, 1, add(6, 5, 5), 0, 0, 2, 2, 0, 0),
      mk(0, 1, addi(5, 0),   0, 0, 0, 0, 0, 0),
      mk(0, 1, NOP,          0, 0, 0, 0, 0, 0),
      mk(0, 1, NOP,          0, 0, 0, 0, 0, 0),
      mk(0, 1, add(6, 5, 5), 0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k].rst, t[k].v, t[k].inst, t[k].r, t[k].si);
      vectors++;
      if (fwd_a_sel !== SELW'(t[k].ea) || fwd_b_sel !== SELW'(t[k].eb) ||
          stall_out !== t[k].es || flush !== t[k].ef) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush, t[k].ea, t[k].eb, t[k].es, t[k].ef);
      end
    end
  endtask

  task automatic test_youngest_x0();
    vec_t t[$] = '{
      mk(0, 1, addi(5, 0),               0, 0, 0, 0, 0, 0),
      mk(0, 1, addi(5, 0),               0, 0, 0, 0, 0, 0),
      mk(0, 1, add(7, 5, 0),             0, 0, 1, 0, 0, 0),
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 0),
      mk(0, 1, enc(0, 5, 1, 2, 5, O_ST), 0, 0, 0, 0, 0, 0),
      mk(0, 1, enc(0, 0, 0, 0, 5, O_BR), 0, 0, 0, 0, 0, 0),
      mk(0, 1, add(7, 5, 5),             0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k].rst, t[k].v, t[k].inst, t[k].r, t[k].si);
      vectors++;
      if (fwd_a_sel !== SELW'(t[k].ea) || fwd_b_sel !== SELW'(t[k].eb) ||
          stall_out !== t[k].es || flush !== t[k].ef) begin
        miscompares++;
        $display("FAIL youngest_x0[%0d]: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush, t[k].ea, t[k].eb, t[k].es, t[k].ef);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t t[$] = '{
      mk(0, 1, NOP,                       0, 0, 0, 0, 0, 0),
      mk(0, 1, NOP,                       0, 0, 0, 0, 0, 0),
      mk(0, 1, enc(0, 0, 1, 2, 8, O_LD),  0, 0, 0, 0, 0, 0),
      mk(0, 1, add(9, 8, 2),              0, 0, 1, 0, 1, 0),
      mk(0, 1, add(9, 8, 2),              0, 0, 2, 0, 0, 0),
      mk(0, 1, add(10, 9, 9),             0, 0, 1, 1, 0, 0)};
    foreach (t[k]) begin
      drive(t[k].rst, t[k].v, t[k].inst, t[k].r, t[k].si);
      vectors++;
      if (fwd_a_sel !== SELW'(t[k].ea) || fwd_b_sel !== SELW'(t[k].eb) ||
          stall_out !== t[k].es || flush !== t[k].ef) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush, t[k].ea, t[k].eb, t[k].es, t[k].ef);
      end
    end
  endtask

  task automatic test_flush();
    vec_t t[$] = '{
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 0),
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 0),
      mk(0, 1, enc(0, 2, 1, 0, 8, O_BR), 1, 0, 0, 0, 0, 1),
      mk(0, 1, addi(10, 0),              1, 0, 0, 0, 0, 1),
      mk(0, 1, addi(11, 0),              1, 0, 0, 0, 0, 1),
      mk(0, 1, add(12, 10, 11),          0, 0, 0, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k].rst, t[k].v, t[k].inst, t[k].r, t[k].si);
      vectors++;
      if (fwd_a_sel !== SELW'(t[k].ea) || fwd_b_sel !== SELW'(t[k].eb) ||
          stall_out !== t[k].es || flush !== t[k].ef) begin
        miscompares++;
        $display("FAIL flush[%0d]: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush, t[k].ea, t[k].eb, t[k].es, t[k].ef);
      end
    end
  endtask

  task automatic test_stall_in();
    vec_t t[$] = '{
      // freeze in the middle of a flush window
      mk(0, 1, enc(0, 0, 0, 0, 8, O_BR), 1, 0, 0, 0, 0, 1),
      mk(0, 1, NOP,                      0, 1, 0, 0, 0, 1),
      mk(0, 1, NOP,                      0, 1, 0, 0, 0, 1),
      mk(0, 1, NOP,                      0, 1, 0, 0, 0, 1),
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 1),
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 1),
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 0),
      // freeze in the middle of a load-use stall
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 0),
      mk(0, 1, enc(0, 0, 1, 2, 8, O_LD), 0, 0, 0, 0, 0, 0),
      mk(0, 1, add(9, 8, 2),             0, 1, 1, 0, 1, 0),
      mk(0, 1, add(9, 8, 2),             0, 1, 1, 0, 1, 0),
      mk(0, 1, add(9, 8, 2),             0, 1, 1, 0, 1, 0),
      mk(0, 1, add(9, 8, 2),             0, 0, 1, 0, 1, 0),
      mk(0, 1, add(9, 8, 2),             0, 0, 2, 0, 0, 0),
      mk(0, 1, add(10, 9, 0),            0, 0, 1, 0, 0, 0)};
    foreach (t[k]) begin
      drive(t[k].rst, t[k].v, t[k].inst, t[k].r, t[k].si);
      vectors++;
      if (fwd_a_sel !== SELW'(t[k].ea) || fwd_b_sel !== SELW'(t[k].eb) ||
          stall_out !== t[k].es || flush !== t[k].ef) begin
        miscompares++;
        $display("FAIL stall_in[%0d]: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush, t[k].ea, t[k].eb, t[k].es, t[k].ef);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    vec_t t[$] = '{
      mk(0, 1, addi(5, 0),               0, 0, 0, 0, 0, 0),
      mk(0, 1, addi(6, 0),               0, 0, 0, 0, 0, 0),
      mk(0, 1, enc(0, 6, 5, 0, 0, O_BR), 1, 0, 2, 1, 0, 1),
      mk(0, 1, NOP,                      0, 0, 0, 0, 0, 1),
      mk(1, 1, add(7, 5, 6),             1, 0, 0, 0, 0, 0),
      mk(0, 1, add(7, 5, 6),             0, 0, 0, 0, 0, 0),
      mk(0, 1, add(8, 7, 7),             0, 0, 1, 1, 0, 0)};
    foreach (t[k]) begin
      drive(t[k].rst, t[k].v, t[k].inst, t[k].r, t[k].si);
      vectors++;
      if (fwd_a_sel !== SELW'(t[k].ea) || fwd_b_sel !== SELW'(t[k].eb) ||
          stall_out !== t[k].es || flush !== t[k].ef) begin
        miscompares++;
        $display("FAIL reset_mid_flush[%0d]: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, fwd_a_sel, fwd_b_sel, stall_out, flush, t[k].ea, t[k].eb, t[k].es, t[k].ef);
      end
    end
  endtask

  task automatic test_random();
    bit [6:0] opcs [11] = '{O_R, O_I, O_LD, O_ST, O_BR, O_JAL, O_JALR,
                            O_AUIPC, O_LUI, O_SYS, O_FENCE};
    logic [31:0] inst;
    for (int k = 0; k < 600; k++) begin
      inst = enc($urandom_range(0, 1) * 32, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), opcs[$urandom_range(0, 10)]);
      drive(($urandom % 100) == 0, ($urandom % 10) != 0, inst,
            ($urandom % 8) == 0, ($urandom % 6) == 0);
      vectors++;
      if (fwd_a_sel !== SELW'(m_a) || fwd_b_sel !== SELW'(m_b) ||
          stall_out !== m_stall || flush !== m_flush) begin
        miscompares++;
        $display("FAIL random[%0d] inst=%h: got a=%0d b=%0d stall=%b flush=%b, want a=%0d b=%0d stall=%b flush=%b",
                 k, inst, fwd_a_sel, fwd_b_sel, stall_out, flush, m_a, m_b, m_stall, m_flush);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_youngest_x0();
    test_load_use();
    test_flush();
    test_stall_in();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
